// File: rtl/modred_stream_ctrl_if.sv
// Stream/reducer bundle for modred_stream_ctrl.
// The "slave" modport is the controller's view; "master" is the view of the
// surrounding logic (operand source, reducer and result sink).
interface modred_stream_ctrl_if #(
    parameter int DATA_LENGTH = 32
);
    logic                   cfg_valid_i;
    logic                   cfg_ready_o;
    logic [DATA_LENGTH-1:0] cfg_m_i;
    logic [DATA_LENGTH-1:0] cfg_m_bl_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [DATA_LENGTH-1:0] in_x_i;
    logic                   red_start_o;
    logic [DATA_LENGTH-1:0] red_x_o;
    logic [DATA_LENGTH-1:0] red_m_o;
    logic [DATA_LENGTH-1:0] red_m_bl_o;
    logic [DATA_LENGTH-1:0] red_result_i;
    logic                   red_valid_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [DATA_LENGTH-1:0] out_result_o;
    logic                   busy_o;
    logic                   err_o;

    modport slave (
        input  cfg_valid_i, cfg_m_i, cfg_m_bl_i, in_valid_i, in_x_i,
               red_result_i, red_valid_i, out_ready_i,
        output cfg_ready_o, in_ready_o, red_start_o, red_x_o, red_m_o, red_m_bl_o,
               out_valid_o, out_result_o, busy_o, err_o
    );

    modport master (
        output cfg_valid_i, cfg_m_i, cfg_m_bl_i, in_valid_i, in_x_i,
               red_result_i, red_valid_i, out_ready_i,
        input  cfg_ready_o, in_ready_o, red_start_o, red_x_o, red_m_o, red_m_bl_o,
               out_valid_o, out_result_o, busy_o, err_o
    );
endinterface

// File: rtl/modred_stream_ctrl.sv
// Front end for a fixed-latency, non-stallable modular-reduction pipeline.
// Holds the modulus, issues at most one operand per cycle and collects the
// results into a credit-protected show-ahead FIFO so backpressure on the
// result stream never loses a result.
// Optional checking: define MODRED_CHECK_EN to enable the sticky err_o
// (result >= m, unexpected reducer valid, reducer watchdog); otherwise err_o = 0.
module modred_stream_ctrl #(
    parameter int DATA_LENGTH = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int RED_LATENCY = 4
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    modred_stream_ctrl_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        UNCONF = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   alive_q;
    logic [DATA_LENGTH-1:0] m_q, m_d;
    logic [DATA_LENGTH-1:0] m_bl_q, m_bl_d;
    logic                   start_q, start_d;
    logic [DATA_LENGTH-1:0] x_q, x_d;
    logic [CW-1:0]          inflight_q, inflight_d;
    logic [AW-1:0]          wptr_q, wptr_d;
    logic [AW-1:0]          rptr_q, rptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [DATA_LENGTH-1:0] mem_q [FIFO_DEPTH];

    logic        cfg_ready;
    logic        in_ready;
    logic        load;
    logic        in_hs;
    logic        push_en;
    logic        pop;
    logic        empty;
    logic        full;
    logic        idle;
    logic        credit_ok;
    logic [CW:0] occupancy;

    // Credits cover the operand waiting in the issue register, results inside
    // the reducer and results already stored, so a push always finds room.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CW'(FIFO_DEPTH));
        occupancy = {1'b0, inflight_q} + {1'b0, count_q} + {{CW{1'b0}}, start_q};
        credit_ok = (occupancy < DEPTH_V);
        idle      = (inflight_q == '0) && empty && !start_q;
    end

    // Control FSM: modulus may only be replaced once nothing is outstanding.
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        load      = 1'b0;
        unique case (state_q)
            UNCONF: begin
                // alive_q keeps cfg_ready_o low while reset is asserted.
                cfg_ready = alive_q;
                if (cfg_ready && bus.cfg_valid_i) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // A pending reconfiguration blocks new operands immediately.
                in_ready = !bus.cfg_valid_i && credit_ok;
                if (bus.cfg_valid_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cfg_ready = idle;
                if (cfg_ready && bus.cfg_valid_i) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = UNCONF;
        endcase
    end

    // Issue register, credit counter and FIFO pointer/count updates.
    always_comb begin
        in_hs   = in_ready && bus.in_valid_i;
        start_d = in_hs;
        x_d     = in_hs ? bus.in_x_i : x_q;
        m_d     = load ? bus.cfg_m_i : m_q;
        m_bl_d  = load ? bus.cfg_m_bl_i : m_bl_q;

        inflight_d = inflight_q;
        if (start_q && !bus.red_valid_i) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!start_q && bus.red_valid_i && (inflight_q != '0)) begin
            inflight_d = inflight_q - CW'(1);
        end

        pop     = !empty && bus.out_ready_i;
        push_en = bus.red_valid_i && (!full || pop);
        wptr_d  = push_en ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (push_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_en && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control state with asynchronous reset; reset discards in-flight work.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= UNCONF;
            alive_q    <= 1'b0;
            m_q        <= '0;
            m_bl_q     <= '0;
            start_q    <= 1'b0;
            inflight_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            alive_q    <= 1'b1;
            m_q        <= m_d;
            m_bl_q     <= m_bl_d;
            start_q    <= start_d;
            inflight_q <= inflight_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
        end
    end

    // Data storage without reset: the operand register and FIFO payload are
    // only observed through qualified (gated) outputs.
    always_ff @(posedge clk_i) begin
        x_q <= x_d;
        if (push_en) begin
            mem_q[wptr_q] <= bus.red_result_i;
        end
    end

    assign bus.cfg_ready_o  = cfg_ready;
    assign bus.in_ready_o   = in_ready;
    assign bus.red_start_o  = start_q;
    assign bus.red_x_o      = start_q ? x_q : '0;
    assign bus.red_m_o      = m_q;
    assign bus.red_m_bl_o   = m_bl_q;
    assign bus.out_valid_o  = !empty;
    assign bus.out_result_o = empty ? '0 : mem_q[rptr_q];
    assign bus.busy_o       = (inflight_q != '0) || !empty;

`ifdef MODRED_CHECK_EN
    localparam int WDOG_LIMIT = 2 * RED_LATENCY;
    localparam int WW         = $clog2(WDOG_LIMIT + 1);

    logic          err_q, err_d;
    logic [WW-1:0] wdog_q, wdog_d;

    // Sticky error on out-of-range results, unexpected valids or a silent reducer.
    always_comb begin
        err_d  = err_q;
        wdog_d = '0;
        if ((inflight_q != '0) && !bus.red_valid_i) begin
            wdog_d = (wdog_q == WW'(WDOG_LIMIT)) ? wdog_q : wdog_q + WW'(1);
        end
        if (bus.red_valid_i && (bus.red_result_i >= m_q)) begin
            err_d = 1'b1;
        end
        if (bus.red_valid_i && (inflight_q == '0)) begin
            err_d = 1'b1;
        end
        if (wdog_q == WW'(WDOG_LIMIT)) begin
            err_d = 1'b1;
        end
    end

    // Error flag and watchdog counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q  <= 1'b0;
            wdog_q <= '0;
        end else begin
            err_q  <= err_d;
            wdog_q <= wdog_d;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_modred_stream_ctrl.sv
// Bench for modred_stream_ctrl: a behavioural fixed-latency reducer feeds the
// DUT, and every accepted operand is scored against x mod m computed here.
module tb_modred_stream_ctrl;
    localparam int DL = 32;
    localparam int FD = 8;
    localparam int RL = 4;
`ifdef MODRED_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    modred_stream_ctrl_if #(.DATA_LENGTH(DL)) bus ();

    modred_stream_ctrl #(
        .DATA_LENGTH(DL),
        .FIFO_DEPTH (FD),
        .RED_LATENCY(RL)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    // Reducer model: start at cycle s gives valid and x mod m at cycle s+RL.
    logic [RL-1:0] pv;
    logic [DL-1:0] pd [RL];
    logic          force_bad;
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            pv <= '0;
        end else begin
            pv    <= {pv[RL-2:0], bus.red_start_o};
            pd[0] <= (bus.red_m_o == '0) ? '0 : bus.red_x_o % bus.red_m_o;
            for (int i = 1; i < RL; i++) pd[i] <= pd[i-1];
        end
    end
    assign bus.red_valid_i  = pv[RL-1];
    assign bus.red_result_i = force_bad ? bus.red_m_o : pd[RL-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Result collector: records every popped result and the cycle it left.
    logic [DL-1:0] got_q [$];
    int            got_cyc [$];
    always @(negedge clk) begin
        if (rst_ni && bus.out_valid_o && bus.out_ready_i) begin
            got_q.push_back(bus.out_result_o);
            got_cyc.push_back(cyc);
        end
    end

    int            n_total = 0;
    int            n_bad = 0;
    int            rd_idx = 0;
    int            stalls = 0;
    logic [DL-1:0] exp_q [$];
    logic [DL-1:0] m_ref = '0;

    function automatic logic [DL-1:0] ref_mod(input logic [DL-1:0] x);
        return (m_ref == '0) ? '0 : x % m_ref;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DL-1:0] x, output int acc_cyc);
        bit done;
        done = 0;
        acc_cyc = -1;
        bus.in_valid_i = 1'b1;
        bus.in_x_i = x;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready_o) begin
                done = 1;
                acc_cyc = cyc;
                exp_q.push_back(ref_mod(x));
            end else begin
                stalls++;
            end
            tick();
        end
        bus.in_valid_i = 1'b0;
        chk("send_accept", 64'(done), 64'd1);
    endtask

    task automatic do_cfg(input logic [DL-1:0] m, input logic [DL-1:0] bl, output logic busy_at_hs);
        bit done;
        done = 0;
        busy_at_hs = 1'b0;
        bus.cfg_valid_i = 1'b1;
        bus.cfg_m_i = m;
        bus.cfg_m_bl_i = bl;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.cfg_ready_o) begin
                done = 1;
                busy_at_hs = bus.busy_o;
                m_ref = m;
            end
            tick();
        end
        bus.cfg_valid_i = 1'b0;
        chk("cfg_accept", 64'(done), 64'd1);
        chk("red_m_o", 64'(bus.red_m_o), 64'(m));
        chk("red_m_bl_o", 64'(bus.red_m_bl_o), 64'(bl));
    endtask

    task automatic wait_settle(input int budget);
        for (int k = 0; k < budget; k++) begin
            if ((got_q.size() - rd_idx) == exp_q.size() && !bus.busy_o) break;
            tick();
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_count"}, 64'(got_q.size() - rd_idx), 64'(exp_q.size()));
        while (exp_q.size() > 0 && rd_idx < got_q.size()) begin
            chk(tag, 64'(got_q[rd_idx]), 64'(exp_q.pop_front()));
            rd_idx++;
        end
        exp_q.delete();
        rd_idx = got_q.size();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int            a;
        int            base;
        int            gaps;
        int            idx;
        int            hold_n;
        int            hold_got;
        logic          hold_rdy;
        logic          b;
        logic [DL-1:0] xs [20];

        bus.cfg_valid_i = 1'b0;
        bus.cfg_m_i = '0;
        bus.cfg_m_bl_i = '0;
        bus.in_valid_i = 1'b0;
        bus.in_x_i = '0;
        bus.out_ready_i = 1'b1;
        force_bad = 1'b0;

        // Reset: every output low.
        repeat (2) @(negedge clk);
        chk("rst_cfg_ready", 64'(bus.cfg_ready_o), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
        chk("rst_red_start", 64'(bus.red_start_o), 64'd0);
        chk("rst_red_x", 64'(bus.red_x_o), 64'd0);
        chk("rst_red_m", 64'(bus.red_m_o), 64'd0);
        chk("rst_red_m_bl", 64'(bus.red_m_bl_o), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_out_result", 64'(bus.out_result_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_err", 64'(bus.err_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        @(negedge clk);
        chk("unconf_in_ready", 64'(bus.in_ready_o), 64'd0);
        tick();

        // 1: single operand, latency and busy_o.
        do_cfg(32'd8380417, 32'd23, b);
        send(32'd8380418, a);
        tick();
        @(negedge clk);
        chk("t1_busy_mid", 64'(bus.busy_o), 64'd1);
        tick();
        wait_settle(50);
        if (got_q.size() > rd_idx) chk("t1_latency", 64'(got_cyc[rd_idx] - a), 64'(RL + 2));
        else chk("t1_latency", 64'(got_q.size() - rd_idx), 64'd1);
        check_all("t1_result");
        @(negedge clk);
        chk("t1_busy_end", 64'(bus.busy_o), 64'd0);
        tick();

        // 2: back-to-back stream 0..15.
        stalls = 0;
        base = got_q.size();
        for (int i = 0; i < 16; i++) send(DL'(i), a);
        chk("t2_stalls", 64'(stalls), 64'd0);
        wait_settle(100);
        gaps = 0;
        for (int i = base + 1; i < got_q.size(); i++) if (got_cyc[i] - got_cyc[i-1] != 1) gaps++;
        chk("t2_gaps", 64'(gaps), 64'd0);
        check_all("t2_result");

        // 3: full backpressure, exactly FD accepted, then release.
        for (int i = 0; i < 20; i++) xs[i] = DL'($urandom);
        idx = 0;
        hold_n = -1;
        hold_got = -1;
        hold_rdy = 1'b1;
        bus.out_ready_i = 1'b0;
        for (int c = 0; c < 300 && idx < 20; c++) begin
            if (c == 30) bus.out_ready_i = 1'b1;
            bus.in_valid_i = 1'b1;
            bus.in_x_i = xs[idx];
            @(negedge clk);
            if (bus.in_ready_o) begin
                exp_q.push_back(ref_mod(xs[idx]));
                idx++;
            end
            if (c == 29) begin
                hold_n = idx;
                hold_rdy = bus.in_ready_o;
                hold_got = got_q.size() - rd_idx;
            end
            tick();
        end
        bus.in_valid_i = 1'b0;
        chk("t3_accepts_held", 64'(hold_n), 64'(FD));
        chk("t3_in_ready_held", 64'(hold_rdy), 64'd0);
        chk("t3_no_output_held", 64'(hold_got), 64'd0);
        chk("t3_all_accepted", 64'(idx), 64'd20);
        wait_settle(200);
        check_all("t3_result");

        // 3b: random valid and random backpressure.
        idx = 0;
        for (int c = 0; c < 1000 && idx < 30; c++) begin
            bus.out_ready_i = ($urandom_range(0, 1) == 1);
            bus.in_valid_i = ($urandom_range(0, 3) != 0);
            bus.in_x_i = DL'($urandom);
            @(negedge clk);
            if (bus.in_valid_i && bus.in_ready_o) begin
                exp_q.push_back(ref_mod(bus.in_x_i));
                idx++;
            end
            tick();
        end
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        chk("t3b_accepted", 64'(idx), 64'd30);
        wait_settle(200);
        check_all("t3b_result");

        // 4: reconfigure mid-stream; old results drain under the old modulus.
        for (int i = 0; i < 6; i++) send(DL'($urandom), a);
        do_cfg(32'd3329, 32'd12, b);
        chk("t4_busy_at_cfg", 64'(b), 64'd0);
        check_all("t4_old");
        send(32'd3330, a);
        for (int i = 0; i < 5; i++) send(DL'($urandom), a);
        wait_settle(100);
        check_all("t4_new");
        chk("t4_err", 64'(bus.err_o), 64'd0);

        // 5: reset with three operands in flight.
        for (int i = 0; i < 3; i++) send(DL'($urandom), a);
        rst_ni = 1'b0;
        base = got_q.size();
        exp_q.delete();
        @(negedge clk);
        chk("t5_red_start", 64'(bus.red_start_o), 64'd0);
        chk("t5_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("t5_busy", 64'(bus.busy_o), 64'd0);
        chk("t5_cfg_ready", 64'(bus.cfg_ready_o), 64'd0);
        chk("t5_red_m", 64'(bus.red_m_o), 64'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        repeat (20) tick();
        chk("t5_nothing_emitted", 64'(got_q.size() - base), 64'd0);
        rd_idx = got_q.size();
        @(negedge clk);
        chk("t5_in_ready_unconf", 64'(bus.in_ready_o), 64'd0);
        tick();

        // 6: out-of-range result from the reducer.
        do_cfg(32'd8380417, 32'd23, b);
        force_bad = 1'b1;
        send(DL'($urandom), a);
        exp_q[exp_q.size()-1] = m_ref;
        wait_settle(50);
        force_bad = 1'b0;
        check_all("t6_result");
        @(negedge clk);
        chk("t6_err", 64'(bus.err_o), 64'(CHK));
        repeat (5) tick();
        @(negedge clk);
        chk("t6_err_held", 64'(bus.err_o), 64'(CHK));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
